// File: rtl/window_scan_controller.sv
// Serpentine 3x3 window scan controller: fetches pixels from image memory,
// drives the window buffer command interface and hands windows to Sobel.
//
// Ports:
//   clk, n_rst                 clock, async active-low reset
//   start                      begin a frame scan (IDLE only)
//   mem_ren/mem_addr           one-cycle read request, addr = y*IMG_W + x
//   mem_rdata/mem_rvalid       read return
//   start_read/data_r          write one pixel into the window buffer
//   start_shift/shift_direc    shift the buffer (00 load, 01 R, 10 L, 11 down)
//   read_done/shift_done       buffer acknowledges, sampled in pulse cycles
//   win_valid/win_ready        window handshake, origin on win_x/win_y
//   busy, frame_done           scan status
//   proto_err                  sticky missing-acknowledge flag
module window_scan_controller #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_rvalid,
    output logic              start_read,
    output logic              start_shift,
    output logic [1:0]        shift_direc,
    output logic [7:0]        data_r,
    input  logic              read_done,
    input  logic              shift_done,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [7:0]        win_x,
    output logic [7:0]        win_y,
    output logic              busy,
    output logic              frame_done,
    output logic              proto_err
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        FETCH,
        WAIT_DATA,
        WRITE,
        WIN_OUT,
        DONE
    } state_t;

    localparam logic [1:0]        D_LOAD  = 2'b00;
    localparam logic [1:0]        D_RIGHT = 2'b01;
    localparam logic [1:0]        D_LEFT  = 2'b10;
    localparam logic [1:0]        D_DOWN  = 2'b11;
    localparam logic [ADDR_W-1:0] W_A     = ADDR_W'(IMG_W);
    localparam logic [7:0]        LAST_X  = 8'(IMG_W - 3);
    localparam logic [7:0]        LAST_Y  = 8'(IMG_H - 3);

    state_t      state_q, state_d;
    logic [7:0]  wx_q, wx_d;
    logic [7:0]  wy_q, wy_d;
    logic        dir_q, dir_d;    // 0 = moving right, 1 = moving left
    logic [1:0]  mode_q, mode_d;  // direction code of the current group
    logic [1:0]  k_q, k_d;        // pixel index within a row/column of 3
    logic [1:0]  r_q, r_d;        // row index, initial load only
    logic [7:0]  pix_q, pix_d;
    logic        perr_q, perr_d;

    logic [ADDR_W-1:0] px, py, addr;
    logic              last_pix;
    logic              at_end;

    // Pixel coordinate of the current fetch within the group.
    always_comb begin
        px = ADDR_W'(wx_q);
        py = ADDR_W'(wy_q);
        unique case (mode_q)
            D_LOAD: begin
                px = ADDR_W'(wx_q) + ADDR_W'(k_q);
                py = ADDR_W'(wy_q) + ADDR_W'(r_q);
            end
            D_RIGHT: begin
                px = ADDR_W'(wx_q) + ADDR_W'(3);
                py = ADDR_W'(wy_q) + ADDR_W'(k_q);
            end
            D_LEFT: begin
                px = ADDR_W'(wx_q) - ADDR_W'(1);
                py = ADDR_W'(wy_q) + ADDR_W'(k_q);
            end
            D_DOWN: begin
                px = ADDR_W'(wx_q) + ADDR_W'(k_q);
                py = ADDR_W'(wy_q) + ADDR_W'(3);
            end
            default: ;
        endcase
        addr = py * W_A + px;
    end

    assign last_pix = (k_q == 2'd2) && ((mode_q != D_LOAD) || (r_q == 2'd2));
    assign at_end   = dir_q ? (wx_q == 8'd0) : (wx_q == LAST_X);

    always_comb begin
        state_d = state_q;
        wx_d    = wx_q;
        wy_d    = wy_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        k_d     = k_q;
        r_d     = r_q;
        pix_d   = pix_q;
        perr_d  = perr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    wx_d    = '0;
                    wy_d    = '0;
                    dir_d   = 1'b0;
                    mode_d  = D_LOAD;
                    k_d     = '0;
                    r_d     = '0;
                    state_d = FETCH;
                end
            end
            SHIFT: begin
                if (!shift_done) perr_d = 1'b1;
                state_d = FETCH;
            end
            FETCH: state_d = WAIT_DATA;
            WAIT_DATA: begin
                if (mem_rvalid) begin
                    pix_d   = mem_rdata;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (!read_done) perr_d = 1'b1;
                if (last_pix) begin
                    state_d = WIN_OUT;
                    // The origin moves only once the new edge is loaded.
                    unique case (mode_q)
                        D_RIGHT: wx_d = wx_q + 8'd1;
                        D_LEFT:  wx_d = wx_q - 8'd1;
                        D_DOWN: begin
                            wy_d  = wy_q + 8'd1;
                            dir_d = ~dir_q;
                        end
                        default: ;
                    endcase
                end else begin
                    state_d = FETCH;
                    if (k_q == 2'd2) begin
                        k_d = '0;
                        r_d = r_q + 2'd1;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
            end
            WIN_OUT: begin
                if (win_ready) begin
                    k_d = '0;
                    r_d = '0;
                    if (!at_end) begin
                        mode_d  = dir_q ? D_LEFT : D_RIGHT;
                        state_d = SHIFT;
                    end else if (wy_q < LAST_Y) begin
                        mode_d  = D_DOWN;
                        state_d = SHIFT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            wx_q    <= '0;
            wy_q    <= '0;
            dir_q   <= 1'b0;
            mode_q  <= D_LOAD;
            k_q     <= '0;
            r_q     <= '0;
            pix_q   <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wx_q    <= wx_d;
            wy_q    <= wy_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            k_q     <= k_d;
            r_q     <= r_d;
            pix_q   <= pix_d;
            perr_q  <= perr_d;
        end
    end

    assign mem_ren     = (state_q == FETCH);
    assign mem_addr    = (state_q == FETCH) ? addr : '0;
    assign start_read  = (state_q == WRITE);
    assign data_r      = (state_q == WRITE) ? pix_q : 8'd0;
    assign start_shift = (state_q == SHIFT);
    assign shift_direc = mode_q;
    assign win_valid   = (state_q == WIN_OUT);
    assign win_x       = wx_q;
    assign win_y       = wy_q;
    assign busy        = (state_q != IDLE) && (state_q != DONE);
    assign frame_done  = (state_q == DONE);
    assign proto_err   = perr_q;

endmodule

// File: tb/tb_window_scan_controller.sv
// Bench for window_scan_controller on a 5x4 image with pixel = address.
// Event-order model built from the serpentine rules, checked every cycle.
module tb_window_scan_controller;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          start = 1'b0;
    logic          mem_ren;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata = 8'd0;
    logic          mem_rvalid = 1'b0;
    logic          start_read;
    logic          start_shift;
    logic [1:0]    shift_direc;
    logic [7:0]    data_r;
    logic          read_done;
    logic          shift_done = 1'b1;
    logic          win_valid;
    logic          win_ready = 1'b1;
    logic [7:0]    win_x;
    logic [7:0]    win_y;
    logic          busy;
    logic          frame_done;
    logic          proto_err;

    window_scan_controller #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk(clk), .n_rst(n_rst), .start(start),
        .mem_ren(mem_ren), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .start_read(start_read), .start_shift(start_shift),
        .shift_direc(shift_direc), .data_r(data_r),
        .read_done(read_done), .shift_done(shift_done),
        .win_valid(win_valid), .win_ready(win_ready),
        .win_x(win_x), .win_y(win_y), .busy(busy),
        .frame_done(frame_done), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk_eq(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Expected event streams.
    int exp_addr[$];
    int exp_rdir[$];
    int exp_sdir[$];
    int exp_wx[$];
    int exp_wy[$];

    function automatic void build();
        int  wx = 0;
        int  wy = 0;
        bit  left = 0;
        bit  row_end;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                exp_addr.push_back(r * W + c);
                exp_rdir.push_back(0);
            end
        exp_wx.push_back(0);
        exp_wy.push_back(0);
        while (1) begin
            row_end = left ? (wx == 0) : (wx == W - 3);
            if (!row_end && !left) begin
                exp_sdir.push_back(1);
                for (int k = 0; k < 3; k++) begin
                    exp_addr.push_back((wy + k) * W + wx + 3);
                    exp_rdir.push_back(1);
                end
                wx++;
            end else if (!row_end) begin
                exp_sdir.push_back(2);
                for (int k = 0; k < 3; k++) begin
                    exp_addr.push_back((wy + k) * W + wx - 1);
                    exp_rdir.push_back(2);
                end
                wx--;
            end else if (wy < H - 3) begin
                exp_sdir.push_back(3);
                for (int k = 0; k < 3; k++) begin
                    exp_addr.push_back((wy + 3) * W + wx + k);
                    exp_rdir.push_back(3);
                end
                wy++;
                left = !left;
            end else begin
                break;
            end
            exp_wx.push_back(wx);
            exp_wy.push_back(wy);
        end
    endfunction

    // Memory model: pixel value = address, configurable latency.
    int lat = 1;
    initial begin
        bit rs;
        int ra;
        bit pend;
        int cnt;
        int pa;
        pend = 0;
        cnt = 0;
        pa = 0;
        forever begin
            @(negedge clk);
            rs = mem_ren;
            ra = int'(mem_addr);
            @(posedge clk);
            #2;
            mem_rvalid = 1'b0;
            if (rs) begin
                pend = 1;
                cnt = lat;
                pa = ra;
            end
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = pa[7:0];
                    pend = 0;
                end
            end
        end
    end

    // Buffer acknowledge, optionally dropped on the 5th write.
    bit fault_en = 0;
    int wr_edges = 0;
    initial forever begin
        @(posedge clk);
        if (start_read) wr_edges++;
    end
    assign read_done = !(fault_en && wr_edges == 4);

    // Back-pressure at window (1,0).
    bit stall_en = 0;
    bit stalled = 0;
    initial forever begin
        @(posedge clk);
        #2;
        if (stall_en && !stalled && win_valid && win_x == 8'd1 && win_y == 8'd0) begin
            win_ready = 1'b0;
            repeat (10) @(posedge clk);
            #2;
            win_ready = 1'b1;
            stalled = 1;
        end
    end

    // Compare process.
    int rd_i = 0, wr_i = 0, sh_i = 0, win_i = 0, frames = 0;
    bit prev_ren = 0, prev_pulse = 0, prev_hold = 0, got_rv = 0, seen9 = 0;
    logic [7:0] hold_x = 0, hold_y = 0;
    int obs_addr[$];
    int obs_wx[$];
    int obs_wy[$];

    initial forever begin
        @(negedge clk);
        if (!n_rst) begin
            rd_i = 0; wr_i = 0; sh_i = 0; win_i = 0;
            prev_ren = 0; prev_pulse = 0; prev_hold = 0; got_rv = 0;
        end else begin
            if (mem_ren) begin
                chk_eq("ren_busy", busy, 1);
                chk_eq("ren_single", prev_ren, 0);
                if (rd_i < exp_addr.size()) begin
                    chk_eq("mem_addr", int'(mem_addr), exp_addr[rd_i]);
                    chk_eq("read_direc", shift_direc, exp_rdir[rd_i]);
                end else chk_eq("extra_read", rd_i, exp_addr.size() - 1);
                if (mem_addr == 9) seen9 = 1;
                obs_addr.push_back(int'(mem_addr));
                rd_i++;
                got_rv = 0;
            end
            if (start_read) begin
                chk_eq("write_after_rvalid", got_rv, 1);
                if (wr_i < exp_addr.size()) begin
                    chk_eq("data_r", data_r, exp_addr[wr_i] % 256);
                    chk_eq("write_direc", shift_direc, exp_rdir[wr_i]);
                end else chk_eq("extra_write", wr_i, exp_addr.size() - 1);
                wr_i++;
            end
            if (start_shift) begin
                if (sh_i < exp_sdir.size())
                    chk_eq("shift_direc", shift_direc, exp_sdir[sh_i]);
                else chk_eq("extra_shift", sh_i, exp_sdir.size() - 1);
                sh_i++;
            end
            if (start_read || start_shift) begin
                chk_eq("pulse_overlap", start_read && start_shift, 0);
                chk_eq("pulse_back_to_back", prev_pulse, 0);
            end
            if (prev_hold) begin
                chk_eq("hold_valid", win_valid, 1);
                chk_eq("hold_x", win_x, hold_x);
                chk_eq("hold_y", win_y, hold_y);
                chk_eq("hold_quiet", mem_ren | start_read | start_shift, 0);
            end
            if (win_valid) begin
                if (win_i < exp_wx.size()) begin
                    chk_eq("win_x", win_x, exp_wx[win_i]);
                    chk_eq("win_y", win_y, exp_wy[win_i]);
                end else chk_eq("extra_window", win_i, exp_wx.size() - 1);
                if (win_ready) begin
                    obs_wx.push_back(win_x);
                    obs_wy.push_back(win_y);
                    win_i++;
                end
            end
            if (frame_done) begin
                chk_eq("windows_per_frame", win_i, exp_wx.size());
                chk_eq("reads_per_frame", rd_i, exp_addr.size());
                chk_eq("done_busy", busy, 0);
                frames++;
                rd_i = 0; wr_i = 0; sh_i = 0; win_i = 0;
            end
            prev_ren = mem_ren;
            prev_pulse = start_read | start_shift;
            prev_hold = win_valid && !win_ready;
            hold_x = win_x;
            hold_y = win_y;
            if (mem_rvalid) got_rv = 1;
        end
    end

    task automatic check_zero(input string tag);
        chk_eq({tag, "_ctl"}, {mem_ren, start_read, start_shift, win_valid,
                               busy, frame_done, proto_err}, 0);
        chk_eq({tag, "_data"}, {mem_addr, data_r, shift_direc, win_x, win_y}, 0);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    task automatic run_frame(input bit dbl_start);
        int f0;
        int n;
        f0 = frames;
        n = 0;
        obs_addr.delete();
        obs_wx.delete();
        obs_wy.delete();
        pulse_start();
        if (dbl_start) begin
            repeat (6) @(posedge clk);
            #2 start = 1'b1;
            @(posedge clk);
            #2 start = 1'b0;
        end
        while (frames == f0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk_eq("frame_timeout", frames != f0, 1);
        repeat (4) @(posedge clk);
        #2;
        chk_eq("single_frame_done", frames - f0, 1);
        chk_eq("idle_busy", busy, 0);
    endtask

    int lit_addr[24] = '{0, 1, 2, 5, 6, 7, 10, 11, 12, 3, 8, 13,
                         4, 9, 14, 17, 18, 19, 6, 11, 16, 5, 10, 15};
    int lit_wx[6] = '{0, 1, 2, 2, 1, 0};
    int lit_wy[6] = '{0, 0, 0, 1, 1, 1};

    initial begin
        build();
        repeat (2) @(posedge clk);
        #2;
        check_zero("reset");
        n_rst = 1'b1;

        lat = 1;
        run_frame(0);
        chk_eq("f1_nreads", obs_addr.size(), 24);
        for (int i = 0; i < 24 && i < obs_addr.size(); i++)
            chk_eq($sformatf("f1_addr%0d", i), obs_addr[i], lit_addr[i]);
        chk_eq("f1_nwin", obs_wx.size(), 6);
        for (int i = 0; i < 6 && i < obs_wx.size(); i++) begin
            chk_eq($sformatf("f1_wx%0d", i), obs_wx[i], lit_wx[i]);
            chk_eq($sformatf("f1_wy%0d", i), obs_wy[i], lit_wy[i]);
        end
        chk_eq("f1_proto_err", proto_err, 0);

        lat = 4;
        run_frame(1);
        chk_eq("f2_nreads", obs_addr.size(), 24);

        lat = 1;
        stall_en = 1;
        run_frame(0);
        chk_eq("f3_stall_seen", stalled, 1);
        stall_en = 0;

        wr_edges = 0;
        fault_en = 1;
        run_frame(0);
        fault_en = 0;
        chk_eq("f4_nwin", obs_wx.size(), 6);
        chk_eq("f4_proto_err", proto_err, 1);
        repeat (3) @(posedge clk);
        #2;
        chk_eq("f4_proto_err_sticky", proto_err, 1);

        lat = 4;
        seen9 = 0;
        pulse_start();
        for (int n = 0; n < 500 && !seen9; n++) @(posedge clk);
        chk_eq("f5_reach_step2", seen9, 1);
        @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        check_zero("abort");
        repeat (2) @(posedge clk);
        #2;
        check_zero("abort_hold");
        n_rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk_eq("post_reset_idle", busy | mem_ren, 0);

        lat = 1;
        run_frame(0);
        chk_eq("f6_nreads", obs_addr.size(), 24);
        if (obs_addr.size() > 0) chk_eq("f6_first_addr", obs_addr[0], 0);
        chk_eq("f6_proto_err", proto_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/window_scan_controller.md
Name: window_scan_controller

Overview:
- Initiator side of the 3x3 window buffer command interface.
- Walks a 3x3 window over an IMG_W x IMG_H 8-bit image in serpentine order.
- Fetches each required pixel from image memory and issues start_read / start_shift / shift_direc commands to the window buffer.
- Presents each completed window to the Sobel compute stage through a valid/ready handshake.

Parameters:
- IMG_W, 64, image width in pixels (>=3)
- IMG_H, 64, image height in pixels (>=3)
- ADDR_W, 16, memory address width; must satisfy IMG_W*IMG_H <= 2^ADDR_W

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request to begin a frame scan; ignored unless in IDLE
- mem_ren  out  1  one-cycle memory read request
- mem_addr  out  ADDR_W  read address = y*IMG_W + x
- mem_rdata  in  8  read data
- mem_rvalid  in  1  mem_rdata valid; arrives >=1 cycle after mem_ren
- start_read  out  1  one-cycle pulse: write data_r into the buffer
- start_shift  out  1  one-cycle pulse: shift buffer contents
- shift_direc  out  2  00 initial load, 01 new column right, 10 new column left, 11 new row bottom
- data_r  out  8  pixel for the buffer; valid while start_read=1
- read_done  in  1  buffer acknowledge, sampled in the start_read cycle
- shift_done  in  1  buffer acknowledge, sampled in the start_shift cycle
- win_valid  out  1  current buffer contents form a complete window
- win_ready  in  1  compute stage accepts the window
- win_x  out  8  window top-left column
- win_y  out  8  window top-left row
- busy  out  1  high from start accept until DONE
- frame_done  out  1  one-cycle pulse after the last window is accepted
- proto_err  out  1  sticky; set if read_done/shift_done is low in its pulse cycle; cleared only by reset

Behaviour:
- Reset values: all outputs 0; state IDLE; window origin (wx,wy)=(0,0); direction register = right.
- Slot mapping (fixed): slot 3r+c holds image pixel (wx+c, wy+2-r). Slots 6-8 hold the top row, 0-2 the bottom row.
- Initial load: 9 reads with shift_direc=00, fetched in order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1),(0,2),(1,2),(2,2).
- Step right: start_shift with 01, then 3 reads with 01 for column wx+3, rows wy, wy+1, wy+2; then wx++.
- Step left: start_shift with 10, then 3 reads with 10 for column wx-1, rows wy..wy+2; then wx--.
- Step down: start_shift with 11, then 3 reads with 11 for row wy+3, columns wx..wx+2; then wy++.
- shift_direc is held constant from the shift pulse through the third read.
- Per-pixel sequence:
  - FETCH: mem_ren=1 for one cycle.
  - WAIT_DATA: hold until mem_rvalid; capture mem_rdata.
  - WRITE: start_read=1 and data_r=captured pixel for exactly one cycle.
- Minimum 3 cycles per pixel; start_read and start_shift are never both high, and never high on consecutive cycles.
- FSM states: IDLE, SHIFT, FETCH, WAIT_DATA, WRITE, WIN_OUT, DONE.
  - IDLE -> FETCH on start (initial load).
  - SHIFT -> FETCH.
  - WRITE -> FETCH while pixels remain in the group (9 for initial load, 3 otherwise); else -> WIN_OUT.
  - WIN_OUT: win_valid=1, win_x/win_y stable until win_ready. On accept, next step is chosen as follows:
    - not at row end: step in the current direction (SHIFT);
    - at row end (wx=IMG_W-3 going right, wx=0 going left) and wy<IMG_H-3: step down, then toggle direction;
    - otherwise -> DONE.
  - DONE: frame_done=1 for one cycle, busy=0 -> IDLE.
- Windows per frame: (IMG_W-2)*(IMG_H-2). IMG_W=3 means no horizontal steps, only down steps.
- An unexpected mem_rvalid outside WAIT_DATA is ignored.
- start while busy is ignored.
- A proto_err condition does not stall the scan.
- n_rst low at any time, including mid-read or mid-handshake, aborts immediately to reset values. A new frame requires a new start.

Test Plan:
- IMG_W=5, IMG_H=4, memory latency 1, win_ready tied high, pixel=addr -> initial mem_addr sequence 0,1,2,5,6,7,10,11,12; first win_valid with (0,0); data_r matches in slot order.
- Same config, continued -> step 1: shift 01, addrs 3,8,13; step 2: 01, addrs 4,9,14; then shift 11, addrs 17,18,19; then shift 10, addrs 16,11,6... wait order rows wy..wy+2 = 6,11,16; 6 windows total; frame_done once; busy falls.
- Memory latency 4 cycles -> mem_ren is single-cycle; start_read occurs only after mem_rvalid; identical address and data order.
- win_ready low for 10 cycles at window (1,0) -> win_valid, win_x=1, win_y=0 held stable; no mem_ren or start_* issued meanwhile.
- read_done forced low on the 5th read -> proto_err=1 and stays 1; scan completes with 6 windows.
- n_rst pulsed during WAIT_DATA of step 2, then start -> outputs 0 after reset; new scan restarts at addr 0 with shift_direc=00.
